mem_port_arbiter: RTL and testbench

- Shares the single memory port (read_m / write_m / address / data) between two requesters: the CPU's multicycle memory stage and a DMA engine.
- Fixed priority to the CPU, with a starvation limit that guarantees the DMA a slot.
- Sequences each access over a fixed memory latency, then returns a one-cycle ack and read data to the winner.
- Sits between cpu/dma and the memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/arb_starve_counter.sv | 35 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and encodings for the CPU/DMA memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int DEFAULT_WORD_SIZE = 16;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_ACK    = 2'd2
   } arb_state_t;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the memory model.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int WORD_SIZE = DEFAULT_WORD_SIZE
);

   // Handshake: a requester raises req with we/addr/wdata and holds them stable
   // until it sees its one-cycle ack; it drops req or presents a new request on
   // the edge after the ack. rdata is valid from the ack onward.
   logic                 cpu_req;
   logic                 cpu_we;
   logic [WORD_SIZE-1:0] cpu_addr;
   logic [WORD_SIZE-1:0] cpu_wdata;
   logic                 cpu_ack;
   logic [WORD_SIZE-1:0] cpu_rdata;

   logic                 dma_req;
   logic                 dma_we;
   logic [WORD_SIZE-1:0] dma_addr;
   logic [WORD_SIZE-1:0] dma_wdata;
   logic                 dma_ack;
   logic [WORD_SIZE-1:0] dma_rdata;

   logic                 read_m;
   logic                 write_m;
   logic [WORD_SIZE-1:0] address;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic [WORD_SIZE-1:0] mem_rdata;

   logic                 owner;
   logic                 busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      input  mem_rdata,
      output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
      output read_m, write_m, address, mem_wdata, owner, busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      output mem_rdata,
      input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
      input  read_m, write_m, address, mem_wdata, owner, busy
   );

endinterface

// File: rtl/arb_starve_counter.sv
// Counts consecutive CPU grants taken while the DMA is waiting; limit_hit
// forces the next arbitration in favour of a pending DMA request.
module arb_starve_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic grant,
   input  logic grant_owner,
   input  logic dma_req,
   output logic limit_hit
);

   localparam int            CW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (grant) begin
         if (grant_owner == OWNER_DMA || !dma_req) begin
            starve_cnt <= '0;
         end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + CW'(1);
         end
      end
   end

   assign limit_hit = (starve_cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU memory stage and a DMA engine:
// CPU priority with a DMA starvation bound, fixed-latency access, one-cycle ack.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   mem_port_arbiter_if.slave  bus,
   output arb_state_t         dbg_state
);

   localparam int               CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   arb_state_t           state, state_next;
   logic [CNT_W-1:0]     cnt, cnt_next;
   logic                 lat_we, we_next;
   logic [WORD_SIZE-1:0] lat_addr, addr_next;
   logic [WORD_SIZE-1:0] lat_wdata, wdata_next;
   logic                 owner_q, owner_next;
   logic [WORD_SIZE-1:0] cpu_rdata_q, cpu_rdata_next;
   logic [WORD_SIZE-1:0] dma_rdata_q, dma_rdata_next;

   logic                 read_m_q, write_m_q;
   logic [WORD_SIZE-1:0] address_q, mem_wdata_q;
   logic                 cpu_ack_q, dma_ack_q, busy_q;

   logic                 grant;
   logic                 limit_hit;
   logic                 dma_wins;

   arb_starve_counter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk         (clk),
      .reset_n     (reset_n),
      .grant       (grant),
      .grant_owner (owner_next),
      .dma_req     (bus.dma_req),
      .limit_hit   (limit_hit)
   );

   assign dma_wins = bus.dma_req && (!bus.cpu_req || limit_hit);

   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      we_next        = lat_we;
      addr_next      = lat_addr;
      wdata_next     = lat_wdata;
      owner_next     = owner_q;
      cpu_rdata_next = cpu_rdata_q;
      dma_rdata_next = dma_rdata_q;
      grant          = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (bus.cpu_req || bus.dma_req) begin
               grant      = 1'b1;
               state_next = ARB_ACCESS;
               cnt_next   = CNT_LOAD;
               if (dma_wins) begin
                  owner_next = OWNER_DMA;
                  we_next    = bus.dma_we;
                  addr_next  = bus.dma_addr;
                  wdata_next = bus.dma_wdata;
               end else begin
                  owner_next = OWNER_CPU;
                  we_next    = bus.cpu_we;
                  addr_next  = bus.cpu_addr;
                  wdata_next = bus.cpu_wdata;
               end
            end
         end
         ARB_ACCESS: begin
            if (cnt == '0) begin
               state_next = ARB_ACK;
               // Memory read data is only valid on the final access cycle.
               if (!lat_we) begin
                  if (owner_q == OWNER_DMA) dma_rdata_next = bus.mem_rdata;
                  else                      cpu_rdata_next = bus.mem_rdata;
               end
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         ARB_ACK:  state_next = ARB_IDLE;
         default:  state_next = ARB_IDLE;
      endcase
   end

   // Port outputs are registered from the next-state values so strobes are glitch-free.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ARB_IDLE;
         cnt         <= '0;
         lat_we      <= 1'b0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
         owner_q     <= OWNER_CPU;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         read_m_q    <= 1'b0;
         write_m_q   <= 1'b0;
         address_q   <= '0;
         mem_wdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         lat_we      <= we_next;
         lat_addr    <= addr_next;
         lat_wdata   <= wdata_next;
         owner_q     <= owner_next;
         cpu_rdata_q <= cpu_rdata_next;
         dma_rdata_q <= dma_rdata_next;
         read_m_q    <= (state_next == ARB_ACCESS) && !we_next;
         write_m_q   <= (state_next == ARB_ACCESS) && we_next;
         address_q   <= (state_next == ARB_ACCESS) ? addr_next : '0;
         mem_wdata_q <= (state_next == ARB_ACCESS && we_next) ? wdata_next : '0;
         cpu_ack_q   <= (state_next == ARB_ACK) && (owner_next == OWNER_CPU);
         dma_ack_q   <= (state_next == ARB_ACK) && (owner_next == OWNER_DMA);
         busy_q      <= (state_next != ARB_IDLE);
      end
   end

   assign bus.read_m    = read_m_q;
   assign bus.write_m   = write_m_q;
   assign bus.address   = address_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.dma_ack   = dma_ack_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dma_rdata = dma_rdata_q;
   assign bus.owner     = owner_q;
   assign bus.busy      = busy_q;
   assign dbg_state     = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a default build (latency 2, limit 4) and a
// latency 1 / limit 1 build, both checked against an expected-grant scoreboard.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int LAT0 = 2;
   localparam int LIM0 = 4;
   localparam int LAT1 = 1;
   localparam int LIM1 = 1;

   typedef struct packed {
      logic        owner;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } txn_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.WORD_SIZE(16)) if0 ();
   mem_port_arbiter_if #(.WORD_SIZE(16)) if1 ();
   arb_state_t dbg_state0, dbg_state1;

   mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(LAT0), .STARVE_LIMIT(LIM0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .bus(if0.slave), .dbg_state(dbg_state0));
   mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(LAT1), .STARVE_LIMIT(LIM1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .bus(if1.slave), .dbg_state(dbg_state1));

   // Memory model: read data is a fixed function of the address.
   function automatic logic [15:0] mem_val(input logic [15:0] a);
      return a ^ 16'hBEFF;
   endfunction

   assign if0.mem_rdata = if0.read_m ? mem_val(if0.address) : 16'h0;
   assign if1.mem_rdata = if1.read_m ? mem_val(if1.address) : 16'h0;

   // ---------------- driver state (0/1 = dut0 cpu/dma, 2/3 = dut1 cpu/dma) ----------------
   logic        drv_req   [4];
   logic        drv_we    [4];
   logic [15:0] drv_addr  [4];
   logic [15:0] drv_wdata [4];
   logic        ack_seen  [4];
   int          present_cycle [4];
   txn_t        stim_q [4][$];

   assign if0.cpu_req = drv_req[0]; assign if0.cpu_we = drv_we[0];
   assign if0.cpu_addr = drv_addr[0]; assign if0.cpu_wdata = drv_wdata[0];
   assign if0.dma_req = drv_req[1]; assign if0.dma_we = drv_we[1];
   assign if0.dma_addr = drv_addr[1]; assign if0.dma_wdata = drv_wdata[1];
   assign if1.cpu_req = drv_req[2]; assign if1.cpu_we = drv_we[2];
   assign if1.cpu_addr = drv_addr[2]; assign if1.cpu_wdata = drv_wdata[2];
   assign if1.dma_req = drv_req[3]; assign if1.dma_we = drv_we[3];
   assign if1.dma_addr = drv_addr[3]; assign if1.dma_wdata = drv_wdata[3];

   // ---------------- monitor views ----------------
   logic        m_read [2], m_write [2], m_owner [2], m_busy [2], m_cack [2], m_dack [2];
   logic [15:0] m_addr [2], m_wd [2], m_crd [2], m_drd [2];
   logic [1:0]  m_state [2];

   assign m_read[0] = if0.read_m;     assign m_read[1] = if1.read_m;
   assign m_write[0] = if0.write_m;   assign m_write[1] = if1.write_m;
   assign m_owner[0] = if0.owner;     assign m_owner[1] = if1.owner;
   assign m_busy[0] = if0.busy;       assign m_busy[1] = if1.busy;
   assign m_cack[0] = if0.cpu_ack;    assign m_cack[1] = if1.cpu_ack;
   assign m_dack[0] = if0.dma_ack;    assign m_dack[1] = if1.dma_ack;
   assign m_addr[0] = if0.address;    assign m_addr[1] = if1.address;
   assign m_wd[0] = if0.mem_wdata;    assign m_wd[1] = if1.mem_wdata;
   assign m_crd[0] = if0.cpu_rdata;   assign m_crd[1] = if1.cpu_rdata;
   assign m_drd[0] = if0.dma_rdata;   assign m_drd[1] = if1.dma_rdata;
   assign m_state[0] = dbg_state0;    assign m_state[1] = dbg_state1;

   // ---------------- scoreboard ----------------
   txn_t        exp_q [2][$];
   logic [15:0] exp_crd [2];
   logic [15:0] exp_drd [2];
   int          strobe_cnt [2];
   int          last_ack [2];
   int          acks_seen [2];
   logic        prev_ack [2];
   logic        gap_chk [2];
   logic        lat_chk [2];
   int          cycle = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int lat_of(input int d);
      return (d == 0) ? LAT0 : LAT1;
   endfunction

   task automatic monitor_dut(input int d);
      txn_t t;
      if (!reset_n) begin
         strobe_cnt[d] = 0;
         prev_ack[d]   = 1'b0;
         return;
      end
      if (m_read[d] || m_write[d]) begin
         strobe_cnt[d]++;
         if (exp_q[d].size() == 0) begin
            check_eq("unexpected_strobe", 32'({m_read[d], m_write[d]}), 0);
         end else begin
            t = exp_q[d][0];
            check_eq("strobe_owner", 32'(m_owner[d]), 32'(t.owner));
            check_eq("read_m", 32'(m_read[d]), 32'(!t.we));
            check_eq("write_m", 32'(m_write[d]), 32'(t.we));
            check_eq("address", 32'(m_addr[d]), 32'(t.addr));
            check_eq("mem_wdata", 32'(m_wd[d]), t.we ? 32'(t.wdata) : 32'h0);
            check_eq("busy_access", 32'(m_busy[d]), 1);
         end
      end
      if (prev_ack[d]) check_eq("ack_width", 32'(m_cack[d] | m_dack[d]), 0);
      if (m_cack[d] || m_dack[d]) begin
         if (exp_q[d].size() == 0) begin
            check_eq("unexpected_ack", 32'({m_cack[d], m_dack[d]}), 0);
         end else begin
            t = exp_q[d].pop_front();
            check_eq("ack_owner", 32'({m_cack[d], m_dack[d]}), t.owner ? 32'h1 : 32'h2);
            check_eq("owner_at_ack", 32'(m_owner[d]), 32'(t.owner));
            check_eq("strobe_cycles", strobe_cnt[d], lat_of(d));
            check_eq("strobes_in_ack", 32'({m_read[d], m_write[d], m_addr[d], m_wd[d]}), 0);
            check_eq("busy_ack", 32'(m_busy[d]), 1);
            if (!t.we) begin
               if (t.owner == OWNER_DMA) exp_drd[d] = mem_val(t.addr);
               else                      exp_crd[d] = mem_val(t.addr);
            end
            check_eq("cpu_rdata", 32'(m_crd[d]), 32'(exp_crd[d]));
            check_eq("dma_rdata", 32'(m_drd[d]), 32'(exp_drd[d]));
            if (gap_chk[d] && last_ack[d] != 0) check_eq("ack_gap", cycle - last_ack[d], lat_of(d) + 2);
            if (lat_chk[d]) check_eq("req_to_ack", cycle - present_cycle[2*d + int'(t.owner)], lat_of(d) + 1);
         end
         last_ack[d]   = cycle;
         strobe_cnt[d] = 0;
         acks_seen[d]++;
      end
      prev_ack[d] = m_cack[d] | m_dack[d];
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         cycle++;
         ack_seen[0] = if0.cpu_ack; ack_seen[1] = if0.dma_ack;
         ack_seen[2] = if1.cpu_ack; ack_seen[3] = if1.dma_ack;
         for (int d = 0; d < 2; d++) monitor_dut(d);
      end
   end

   // ---------------- driver ----------------
   initial begin : driver
      txn_t t;
      for (int i = 0; i < 4; i++) begin
         drv_req[i] = 1'b0; drv_we[i] = 1'b0; drv_addr[i] = '0; drv_wdata[i] = '0;
         ack_seen[i] = 1'b0; present_cycle[i] = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (drv_req[i] && ack_seen[i]) drv_req[i] = 1'b0;
            if (!drv_req[i] && stim_q[i].size() != 0) begin
               t = stim_q[i].pop_front();
               drv_req[i]   = 1'b1;
               drv_we[i]    = t.we;
               drv_addr[i]  = t.addr;
               drv_wdata[i] = t.wdata;
               present_cycle[i] = cycle + 1;
            end
         end
      end
   end

   task automatic issue(input int d, input logic own, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata);
      txn_t t;
      t.owner = own; t.we = we; t.addr = addr; t.wdata = wdata;
      exp_q[d].push_back(t);
      stim_q[2*d + int'(own)].push_back(t);
   endtask

   task automatic wait_done(input int d, input int budget);
      int n = 0;
      while (exp_q[d].size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check_eq("drain", exp_q[d].size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_all_zero(input int d);
      check_eq("rst_strobes", 32'({m_read[d], m_write[d]}), 0);
      check_eq("rst_address", 32'(m_addr[d]), 0);
      check_eq("rst_mem_wdata", 32'(m_wd[d]), 0);
      check_eq("rst_acks", 32'({m_cack[d], m_dack[d]}), 0);
      check_eq("rst_rdata", {m_crd[d], m_drd[d]}, 0);
      check_eq("rst_owner_busy", 32'({m_owner[d], m_busy[d]}), 0);
      check_eq("rst_state", 32'(m_state[d]), 32'(ARB_IDLE));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin : test
      int   dma_ack_cnt;
      logic [15:0] a;
      reset_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         exp_crd[d] = '0; exp_drd[d] = '0; strobe_cnt[d] = 0; last_ack[d] = 0;
         acks_seen[d] = 0; prev_ack[d] = 1'b0; gap_chk[d] = 1'b0; lat_chk[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) check_all_zero(d);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single CPU read, then single DMA write.
      lat_chk[0] = 1'b1;
      issue(0, OWNER_CPU, 1'b0, 16'h0010, 16'h0000);
      wait_done(0, 40);
      check_eq("cpu_read_beef", 32'(m_crd[0]), 32'hBEEF);
      issue(0, OWNER_DMA, 1'b1, 16'h0020, 16'h1234);
      wait_done(0, 40);
      check_eq("dma_write_owner", 32'(m_owner[0]), 1);
      check_eq("dma_rdata_kept", 32'(m_drd[0]), 0);
      lat_chk[0] = 1'b0;

      // Simultaneous single requests: CPU first, DMA in the next IDLE.
      gap_chk[0] = 1'b1; last_ack[0] = 0;
      issue(0, OWNER_CPU, 1'b0, 16'h0100, 16'h0000);
      issue(0, OWNER_DMA, 1'b0, 16'h0200, 16'h0000);
      wait_done(0, 60);

      // Both held continuously: C C C C D C C C C D C.
      last_ack[0] = 0;
      for (int k = 0; k < 11; k++) begin
         a = 16'($urandom_range(0, 16'hFFFF));
         if (k == 4 || k == 9)
            issue(0, OWNER_DMA, 1'($urandom_range(0, 1)), a, 16'($urandom_range(0, 16'hFFFF)));
         else
            issue(0, OWNER_CPU, 1'($urandom_range(0, 1)), a, 16'($urandom_range(0, 16'hFFFF)));
      end
      wait_done(0, 200);
      gap_chk[0] = 1'b0;

      // Reset during the first ACCESS cycle of a DMA read.
      issue(0, OWNER_DMA, 1'b0, 16'h0300, 16'h0000);
      begin
         int n = 0;
         while (!m_busy[0] && n < 20) begin
            @(negedge clk);
            n++;
         end
         check_eq("rst_test_started", 32'(m_busy[0]), 1);
      end
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero(0);
      exp_q[0].delete();
      stim_q[1].delete();
      drv_req[1] = 1'b0;
      for (int d = 0; d < 2; d++) begin
         exp_crd[d] = '0; exp_drd[d] = '0;
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      dma_ack_cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (m_dack[0]) dma_ack_cnt++;
      end
      check_eq("no_ack_after_reset", dma_ack_cnt, 0);
      lat_chk[0] = 1'b1;
      issue(0, OWNER_DMA, 1'b0, 16'h0300, 16'h0000);
      wait_done(0, 40);
      check_eq("dma_reissue_rdata", 32'(m_drd[0]), 32'hBDFF);
      lat_chk[0] = 1'b0;

      // Latency 1 / limit 1 build: back-to-back CPU reads every 3 cycles.
      gap_chk[1] = 1'b1; last_ack[1] = 0;
      for (int k = 0; k < 4; k++) issue(1, OWNER_CPU, 1'b0, 16'($urandom_range(0, 16'hFFFF)), 16'h0000);
      wait_done(1, 60);
      check_eq("dut1_acks", acks_seen[1], 4);

      // With DMA pending, grants alternate: C D C D C C.
      last_ack[1] = 0;
      for (int k = 0; k < 6; k++) begin
         a = 16'($urandom_range(0, 16'hFFFF));
         if (k == 1 || k == 3) issue(1, OWNER_DMA, 1'b0, a, 16'h0000);
         else                  issue(1, OWNER_CPU, 1'($urandom_range(0, 1)), a, 16'($urandom_range(0, 16'hFFFF)));
      end
      wait_done(1, 80);
      gap_chk[1] = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
